// File: rtl/fm_rom_server_pkg.sv
// Shared constants for the FM-index table server: base codes, Occ byte lanes,
// the Occ(-1) address and the load FSM encoding.
package fm_rom_server_pkg;

  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;

  localparam int OCC_LANE_W     = 8;
  localparam int OCC_LANE_A_LSB = 0;
  localparam int OCC_LANE_C_LSB = 8;
  localparam int OCC_LANE_G_LSB = 16;
  localparam int OCC_LANE_T_LSB = 24;

  localparam logic [7:0] OCC_NEG1 = 8'hFF;

  localparam int C_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_C   = 3'd1,
    ST_LOAD_OCC = 3'd2,
    ST_LOAD_RD  = 3'd3,
    ST_READY    = 3'd4
  } load_state_e;

  // Count for one base out of a packed Occ word.
  function automatic logic [7:0] occ_lane(input logic [31:0] word, input logic [1:0] base);
    return word[OCC_LANE_W * base +: OCC_LANE_W];
  endfunction

endpackage

// File: rtl/fm_rom_server_if.sv
// Load stream plus the three table request/response ports of the FM-index server.
interface fm_rom_server_if;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        rom_ready;

  logic        ce_rom_C;
  logic [1:0]  addr_rom_C;
  logic [7:0]  data;

  logic        ce_rom_Occ;
  logic [7:0]  addr1_rom_Occ;
  logic [7:0]  addr2_rom_Occ;
  logic [31:0] data_1;
  logic [31:0] data_2;

  logic        ce_rom_read_and_D;
  logic [7:0]  addr_rom_read_and_D;
  logic [7:0]  d_i;
  logic [1:0]  read_i;

  logic        c_valid;
  logic        occ_valid;
  logic        rd_valid;

  modport master (
    output load_start, load_valid, load_data,
    output ce_rom_C, addr_rom_C,
    output ce_rom_Occ, addr1_rom_Occ, addr2_rom_Occ,
    output ce_rom_read_and_D, addr_rom_read_and_D,
    input  load_ready, load_done, rom_ready,
    input  data, data_1, data_2, d_i, read_i,
    input  c_valid, occ_valid, rd_valid
  );

  modport slave (
    input  load_start, load_valid, load_data,
    input  ce_rom_C, addr_rom_C,
    input  ce_rom_Occ, addr1_rom_Occ, addr2_rom_Occ,
    input  ce_rom_read_and_D, addr_rom_read_and_D,
    output load_ready, load_done, rom_ready,
    output data, data_1, data_2, d_i, read_i,
    output c_valid, occ_valid, rd_valid
  );
endinterface

// File: rtl/fm_rom_bank.sv
// Synchronous-write, registered-read table with one write port and two
// independent read ports; maps onto block RAM.
module fm_rom_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re1,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1,
  input  logic             re2,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata2
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata1_q;
  logic [WIDTH-1:0] rdata2_q;

  // No reset on the read registers: the owner masks them until a fresh read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re1) begin
      rdata1_q <= mem[raddr1];
    end
    if (re2) begin
      rdata2_q <= mem[raddr2];
    end
  end

  assign rdata1 = rdata1_q;
  assign rdata2 = rdata2_q;

endmodule

// File: rtl/fm_rom_server.sv
// FM-index table server: streams C, Occ and read/D tables in after reset, then
// answers one-cycle-latency read requests on three independent ports.
module fm_rom_server #(
  parameter int OCC_DEPTH = 255,
  parameter int RD_DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  fm_rom_server_if.slave    bus
);
  import fm_rom_server_pkg::*;

  localparam int OCC_AW = (OCC_DEPTH > 1) ? $clog2(OCC_DEPTH) : 1;
  localparam int RD_AW  = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam int C_AW   = 2;

  localparam logic [8:0] C_LAST   = 9'(C_DEPTH - 1);
  localparam logic [8:0] OCC_LAST = 9'(OCC_DEPTH - 1);
  localparam logic [8:0] RD_LAST  = 9'(RD_DEPTH - 1);

  load_state_e state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic        load_done_q, load_done_d;

  logic c_valid_q, c_valid_d;
  logic occ_valid_q, occ_valid_d;
  logic rd_valid_q, rd_valid_d;
  // *_ok_q: the held response came from an in-range read since reset.
  logic c_ok_q, c_ok_d;
  logic occ1_ok_q, occ1_ok_d;
  logic occ2_ok_q, occ2_ok_d;
  logic rd_ok_q, rd_ok_d;

  logic load_ready;
  logic rom_ready;
  logic accept;
  logic we_c, we_occ, we_rd;
  logic c_fire, occ_fire, rd_fire;
  logic occ1_in, occ2_in, rd_in;

  logic [7:0]  c_rd;
  logic [7:0]  c_rd2_unused;
  logic [31:0] occ_rd1, occ_rd2;
  logic [9:0]  rd_rd;
  logic [9:0]  rd_rd2_unused;

  assign load_ready = (state_q == ST_LOAD_C) || (state_q == ST_LOAD_OCC) ||
                      (state_q == ST_LOAD_RD);
  assign rom_ready  = (state_q == ST_READY);
  // A word arriving with load_start is dropped so the reload begins cleanly at 0.
  assign accept     = bus.load_valid && load_ready && !bus.load_start;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    load_done_d = 1'b0;
    if (bus.load_start) begin
      state_d = ST_LOAD_C;
      idx_d   = '0;
    end else if (accept) begin
      idx_d = idx_q + 9'd1;
      unique case (state_q)
        ST_LOAD_C: begin
          if (idx_q == C_LAST) begin
            state_d = ST_LOAD_OCC;
            idx_d   = '0;
          end
        end
        ST_LOAD_OCC: begin
          if (idx_q == OCC_LAST) begin
            state_d = ST_LOAD_RD;
            idx_d   = '0;
          end
        end
        ST_LOAD_RD: begin
          if (idx_q == RD_LAST) begin
            state_d     = ST_READY;
            idx_d       = '0;
            load_done_d = 1'b1;
          end
        end
        default: begin
          idx_d = idx_q;
        end
      endcase
    end
  end

  assign we_c   = accept && (state_q == ST_LOAD_C);
  assign we_occ = accept && (state_q == ST_LOAD_OCC);
  assign we_rd  = accept && (state_q == ST_LOAD_RD);

  assign c_fire   = bus.ce_rom_C && rom_ready;
  assign occ_fire = bus.ce_rom_Occ && rom_ready;
  assign rd_fire  = bus.ce_rom_read_and_D && rom_ready;

  // Occ(-1) and rows past the stored range read as an all-zero count word.
  assign occ1_in = ({1'b0, bus.addr1_rom_Occ} < 9'(OCC_DEPTH)) &&
                   (bus.addr1_rom_Occ != OCC_NEG1);
  assign occ2_in = ({1'b0, bus.addr2_rom_Occ} < 9'(OCC_DEPTH)) &&
                   (bus.addr2_rom_Occ != OCC_NEG1);
  assign rd_in   = ({1'b0, bus.addr_rom_read_and_D} < 9'(RD_DEPTH));

  always_comb begin
    c_valid_d   = c_fire;
    occ_valid_d = occ_fire;
    rd_valid_d  = rd_fire;
    c_ok_d      = c_fire ? 1'b1 : c_ok_q;
    occ1_ok_d   = occ_fire ? occ1_in : occ1_ok_q;
    occ2_ok_d   = occ_fire ? occ2_in : occ2_ok_q;
    rd_ok_d     = rd_fire ? rd_in : rd_ok_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      load_done_q <= 1'b0;
      c_valid_q   <= 1'b0;
      occ_valid_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      c_ok_q      <= 1'b0;
      occ1_ok_q   <= 1'b0;
      occ2_ok_q   <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      load_done_q <= load_done_d;
      c_valid_q   <= c_valid_d;
      occ_valid_q <= occ_valid_d;
      rd_valid_q  <= rd_valid_d;
      c_ok_q      <= c_ok_d;
      occ1_ok_q   <= occ1_ok_d;
      occ2_ok_q   <= occ2_ok_d;
      rd_ok_q     <= rd_ok_d;
    end
  end

  fm_rom_bank #(.WIDTH(8), .DEPTH(C_DEPTH)) u_c_bank (
    .clk    (clk),
    .we     (we_c),
    .waddr  (idx_q[C_AW-1:0]),
    .wdata  (bus.load_data[7:0]),
    .re1    (c_fire),
    .raddr1 (bus.addr_rom_C),
    .rdata1 (c_rd),
    .re2    (1'b0),
    .raddr2 ('0),
    .rdata2 (c_rd2_unused)
  );

  fm_rom_bank #(.WIDTH(32), .DEPTH(OCC_DEPTH)) u_occ_bank (
    .clk    (clk),
    .we     (we_occ),
    .waddr  (idx_q[OCC_AW-1:0]),
    .wdata  (bus.load_data),
    .re1    (occ_fire && occ1_in),
    .raddr1 (bus.addr1_rom_Occ[OCC_AW-1:0]),
    .rdata1 (occ_rd1),
    .re2    (occ_fire && occ2_in),
    .raddr2 (bus.addr2_rom_Occ[OCC_AW-1:0]),
    .rdata2 (occ_rd2)
  );

  fm_rom_bank #(.WIDTH(10), .DEPTH(RD_DEPTH)) u_rd_bank (
    .clk    (clk),
    .we     (we_rd),
    .waddr  (idx_q[RD_AW-1:0]),
    .wdata  (bus.load_data[9:0]),
    .re1    (rd_fire && rd_in),
    .raddr1 (bus.addr_rom_read_and_D[RD_AW-1:0]),
    .rdata1 (rd_rd),
    .re2    (1'b0),
    .raddr2 ('0),
    .rdata2 (rd_rd2_unused)
  );

  assign bus.load_ready = load_ready;
  assign bus.load_done  = load_done_q;
  assign bus.rom_ready  = rom_ready;
  assign bus.c_valid    = c_valid_q;
  assign bus.occ_valid  = occ_valid_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.data       = c_ok_q    ? c_rd        : 8'h0;
  assign bus.data_1     = occ1_ok_q ? occ_rd1     : 32'h0;
  assign bus.data_2     = occ2_ok_q ? occ_rd2     : 32'h0;
  assign bus.d_i        = rd_ok_q   ? rd_rd[7:0]  : 8'h0;
  assign bus.read_i     = rd_ok_q   ? rd_rd[9:8]  : 2'b00;

endmodule

// File: tb/tb_fm_rom_server.sv
// Self-checking bench for fm_rom_server: spec-pattern table vectors, random
// requests against a table model, reload/reset corner sequences, small-depth masking.
module tb_fm_rom_server;
  import fm_rom_server_pkg::*;

  localparam int OCC_D   = 255;
  localparam int RD_D    = 256;
  localparam int N_WORDS = 4 + OCC_D + RD_D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fm_rom_server_if bus ();
  fm_rom_server_if sbus ();

  fm_rom_server #(.OCC_DEPTH(OCC_D), .RD_DEPTH(RD_D)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  fm_rom_server #(.OCC_DEPTH(5), .RD_DEPTH(6)) dut_small (
    .clk(clk), .rst_n(rst_n), .bus(sbus.slave)
  );

  int errors = 0;
  int checks = 0;

  // source tables for the next load, and the model of what the DUT holds
  logic [7:0]  src_c [4];
  logic [31:0] src_occ [256];
  logic [7:0]  src_d [256];
  logic [1:0]  src_r [256];
  logic [7:0]  m_c [4];
  logic [31:0] m_occ [256];
  logic [7:0]  m_d [256];
  logic [1:0]  m_r [256];
  bit          m_ready = 1'b0;
  logic [7:0]  e_data = '0;
  logic [31:0] e_d1 = '0, e_d2 = '0;
  logic [7:0]  e_di = '0;
  logic [1:0]  e_ri = '0;

  typedef struct packed {
    logic        c_en;
    logic [1:0]  ca;
    logic        o_en;
    logic [7:0]  a1;
    logic [7:0]  a2;
    logic        r_en;
    logic [7:0]  ra;
    logic [7:0]  x_data;
    logic [31:0] x_d1;
    logic [31:0] x_d2;
    logic [7:0]  x_di;
    logic [1:0]  x_ri;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] occ_ref(input logic [7:0] a);
    if (a == 8'hFF || int'(a) >= OCC_D) return 32'h0;
    return m_occ[a];
  endfunction

  function automatic logic [31:0] stream_word(input int k);
    logic [31:0] junk;
    junk = $urandom;
    if (k < 4) return {junk[31:8], src_c[k]};
    if (k < 4 + OCC_D) return src_occ[k - 4];
    return {junk[31:10], src_r[k - 4 - OCC_D], src_d[k - 4 - OCC_D]};
  endfunction

  task automatic model_write(input int k, input logic [31:0] w);
    if (k < 4) m_c[k] = w[7:0];
    else if (k < 4 + OCC_D) m_occ[k - 4] = w;
    else begin
      m_d[k - 4 - OCC_D] = w[7:0];
      m_r[k - 4 - OCC_D] = w[9:8];
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    e_data = '0; e_d1 = '0; e_d2 = '0; e_di = '0; e_ri = '0;
  endtask

  // One request cycle on the main DUT, checked against the model.
  task automatic issue(input bit c_en, input logic [1:0] ca, input bit o_en,
                       input logic [7:0] a1, input logic [7:0] a2,
                       input bit r_en, input logic [7:0] ra, input string tag);
    bus.ce_rom_C = c_en; bus.addr_rom_C = ca;
    bus.ce_rom_Occ = o_en; bus.addr1_rom_Occ = a1; bus.addr2_rom_Occ = a2;
    bus.ce_rom_read_and_D = r_en; bus.addr_rom_read_and_D = ra;
    step();
    if (m_ready && c_en) e_data = m_c[ca];
    if (m_ready && o_en) begin
      e_d1 = occ_ref(a1);
      e_d2 = occ_ref(a2);
    end
    if (m_ready && r_en) begin
      e_di = (int'(ra) < RD_D) ? m_d[ra] : 8'h0;
      e_ri = (int'(ra) < RD_D) ? m_r[ra] : 2'b0;
    end
    chk({tag, "_c_valid"}, bus.c_valid, m_ready && c_en);
    chk({tag, "_occ_valid"}, bus.occ_valid, m_ready && o_en);
    chk({tag, "_rd_valid"}, bus.rd_valid, m_ready && r_en);
    chk({tag, "_data"}, bus.data, e_data);
    chk({tag, "_data_1"}, bus.data_1, e_d1);
    chk({tag, "_data_2"}, bus.data_2, e_d2);
    chk({tag, "_d_i"}, bus.d_i, e_di);
    chk({tag, "_read_i"}, bus.read_i, e_ri);
    bus.ce_rom_C = 0; bus.ce_rom_Occ = 0; bus.ce_rom_read_and_D = 0;
  endtask

  // Start pulse (with a stray word that must be dropped), then stream words.
  task automatic load_tables(input int stop_after, input bit gaps);
    int k;
    int cyc;
    bit v;
    logic [31:0] w;
    bus.load_start = 1; bus.load_valid = 1; bus.load_data = 32'hDEAD_BEEF;
    step();
    bus.load_start = 0;
    m_ready = 1'b0;
    chk("start_rom_ready", bus.rom_ready, 0);
    chk("start_load_ready", bus.load_ready, 1);
    k = 0;
    cyc = 0;
    while (k < N_WORDS && k != stop_after && cyc < 4000) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      w = v ? stream_word(k) : $urandom;
      bus.load_valid = v; bus.load_data = w;
      step();
      cyc++;
      if (v) begin
        model_write(k, w);
        k++;
      end
      if (k == N_WORDS) begin
        chk("load_done_pulse", bus.load_done, 1);
        chk("load_rom_ready", bus.rom_ready, 1);
      end else begin
        chk("load_done_early", bus.load_done, 0);
        chk("load_rom_ready_low", bus.rom_ready, 0);
        chk("load_ready_high", bus.load_ready, 1);
      end
    end
    bus.load_valid = 0;
    if (cyc >= 4000) chk("load_timeout", 32'(k), 32'(N_WORDS));
    if (k == N_WORDS) begin
      m_ready = 1'b1;
      if (!gaps) chk("load_cycles", 32'(cyc), 32'(N_WORDS));
      step();
      chk("load_done_one_cycle", bus.load_done, 0);
      chk("ready_after_done", bus.rom_ready, 1);
      chk("load_ready_off", bus.load_ready, 0);
    end
  endtask

  task automatic random_reads(input int n);
    logic [7:0] a1, a2;
    for (int i = 0; i < n; i++) begin
      a1 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      a2 = ($urandom_range(0, 5) == 0) ? a1 : 8'($urandom);
      issue($urandom_range(0, 1) == 1, 2'($urandom), $urandom_range(0, 1) == 1, a1, a2,
            $urandom_range(0, 1) == 1, 8'($urandom), "rnd");
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_rom_ready"}, bus.rom_ready, 0);
    chk({tag, "_load_ready"}, bus.load_ready, 0);
    chk({tag, "_load_done"}, bus.load_done, 0);
    chk({tag, "_valids"}, {bus.c_valid, bus.occ_valid, bus.rd_valid}, 0);
    chk({tag, "_data"}, bus.data, 0);
    chk({tag, "_data_1"}, bus.data_1, 0);
    chk({tag, "_data_2"}, bus.data_2, 0);
    chk({tag, "_d_i_read_i"}, {bus.d_i, bus.read_i}, 0);
  endtask

  task automatic small_req(input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] ra,
                           input logic [31:0] x1, input logic [31:0] x2,
                           input logic [7:0] xd, input logic [1:0] xr);
    sbus.ce_rom_Occ = 1; sbus.addr1_rom_Occ = a1; sbus.addr2_rom_Occ = a2;
    sbus.ce_rom_read_and_D = 1; sbus.addr_rom_read_and_D = ra;
    step();
    chk("small_valids", {sbus.occ_valid, sbus.rd_valid}, 2'b11);
    chk("small_data_1", sbus.data_1, x1);
    chk("small_data_2", sbus.data_2, x2);
    chk("small_d_i", sbus.d_i, xd);
    chk("small_read_i", sbus.read_i, xr);
    sbus.ce_rom_Occ = 0; sbus.ce_rom_read_and_D = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0;
    bus.ce_rom_C = 0; bus.addr_rom_C = '0;
    bus.ce_rom_Occ = 0; bus.addr1_rom_Occ = '0; bus.addr2_rom_Occ = '0;
    bus.ce_rom_read_and_D = 0; bus.addr_rom_read_and_D = '0;
    sbus.load_start = 0; sbus.load_valid = 0; sbus.load_data = '0;
    sbus.ce_rom_C = 0; sbus.addr_rom_C = '0;
    sbus.ce_rom_Occ = 0; sbus.addr1_rom_Occ = '0; sbus.addr2_rom_Occ = '0;
    sbus.ce_rom_read_and_D = 0; sbus.addr_rom_read_and_D = '0;

    // ce/addr fields, then expected data for the enabled ports
    vecs[0] = '{1'b1, 2'b10, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'd9,  32'h0, 32'h0, 8'h0, 2'd0};
    vecs[1] = '{1'b0, 2'b00, 1'b1, 8'hFF, 8'h03, 1'b0, 8'h00, 8'd0,  32'h0, 32'h0C090603, 8'h0, 2'd0};
    vecs[2] = '{1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h07, 8'd0,  32'h0, 32'h0, 8'h07, 2'd3};
    vecs[3] = '{1'b1, 2'b11, 1'b1, 8'h01, 8'h01, 1'b1, 8'hFF, 8'd14, 32'h04030201, 32'h04030201, 8'hFF, 2'd3};
    vecs[4] = '{1'b1, 2'b00, 1'b1, 8'hFE, 8'h00, 1'b1, 8'h00, 8'd0,  32'hFAFBFCFE, 32'h0, 8'h00, 2'd0};
    vecs[5] = '{1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 1'b1, 8'h82, 8'd5,  32'h0, 32'h0, 8'h82, 2'd2};

    repeat (3) step();
    rst_n = 1;
    check_zero_outputs("reset");

    // requests before any load are ignored
    issue(1, 2'b10, 1, 8'h03, 8'h04, 1, 8'h07, "preload");

    src_c[0] = 8'd0; src_c[1] = 8'd5; src_c[2] = 8'd9; src_c[3] = 8'd14;
    for (int r = 0; r < 256; r++) begin
      src_occ[r] = 32'h04030201 * 32'(r);
      src_d[r] = 8'(r);
      src_r[r] = 2'(r % 4);
    end
    load_tables(-1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].c_en, vecs[i].ca, vecs[i].o_en, vecs[i].a1, vecs[i].a2,
            vecs[i].r_en, vecs[i].ra, $sformatf("vec%0d", i));
      if (vecs[i].c_en) chk($sformatf("vec%0d_tbl_data", i), bus.data, vecs[i].x_data);
      if (vecs[i].o_en) begin
        chk($sformatf("vec%0d_tbl_d1", i), bus.data_1, vecs[i].x_d1);
        chk($sformatf("vec%0d_tbl_d2", i), bus.data_2, vecs[i].x_d2);
      end
      if (vecs[i].r_en) begin
        chk($sformatf("vec%0d_tbl_d_i", i), bus.d_i, vecs[i].x_di);
        chk($sformatf("vec%0d_tbl_read_i", i), bus.read_i, vecs[i].x_ri);
      end
    end

    random_reads(200);

    // restart mid-LOAD_OCC with fresh random tables
    for (int r = 0; r < 4; r++) src_c[r] = 8'($urandom);
    for (int r = 0; r < 256; r++) begin
      src_occ[r] = $urandom;
      src_d[r] = 8'($urandom);
      src_r[r] = 2'($urandom);
    end
    load_tables(100, 1'b1);
    issue(1, 2'b01, 1, 8'h05, 8'h06, 1, 8'h09, "midload");
    load_tables(-1, 1'b1);
    random_reads(300);

    // reset in READY clears every output; reads stay ignored until reload
    issue(1, 2'b11, 1, 8'h10, 8'h20, 1, 8'h30, "prereset");
    rst_n = 0;
    step();
    rst_n = 1;
    model_reset();
    check_zero_outputs("ready_reset");
    issue(1, 2'b11, 1, 8'h10, 8'h20, 1, 8'h30, "postreset");

    // small-depth instance: out-of-range addresses read as zero
    sbus.load_start = 1;
    step();
    sbus.load_start = 0;
    for (int k = 0; k < 15; k++) begin
      sbus.load_valid = 1;
      if (k < 4) sbus.load_data = 32'hABCD_0000 | 32'(k + 1);
      else if (k < 9) sbus.load_data = 32'h11111111 * 32'(k - 3);
      else sbus.load_data = {22'h3FFFFF, 2'((k - 9) % 4), 8'(8'h40 + (k - 9))};
      step();
      chk("small_load_done", sbus.load_done, (k == 14) ? 1 : 0);
    end
    sbus.load_valid = 0;
    small_req(8'h04, 8'h05, 8'h05, 32'h55555555, 32'h0, 8'h45, 2'd1);
    small_req(8'hFF, 8'h00, 8'h06, 32'h0, 32'h11111111, 8'h00, 2'd0);
    small_req(8'hC8, 8'h02, 8'hC8, 32'h0, 32'h33333333, 8'h00, 2'd0);
    sbus.ce_rom_C = 1; sbus.addr_rom_C = 2'b11;
    step();
    sbus.ce_rom_C = 0;
    chk("small_c", {sbus.c_valid, sbus.data}, {1'b1, 8'd4});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
